decoder_sweep_checker: RTL

- Synthesizable, self-checking stimulus and checker for N-bit to 2^N one-hot decoders.
- Sweeps every input code up or down on a start/done handshake.
- Waits a programmable latency per vector, then compares the DUT output against an internally generated one-hot reference.
- Reports error count, first failing code and pass/fail.
- Sits beside any decoder DUT in lab test harnesses; can also drive hardware self-test.

---
 rtl/decoder_test_pkg.sv | 20 ++
 rtl/decoder_ref_onehot.sv | 31 +++
 rtl/decoder_sweep_checker.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/decoder_test_pkg.sv
// decoder_test_pkg: shared encodings for the decoder sweep checker and related decoder benches.
// Revision: 1.0
`default_nettype none

package decoder_test_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Pass flag used when the disable-pass sweep is built in
    localparam logic PASS_ONE = 1'b0;
    localparam logic PASS_TWO = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

`default_nettype wire

// File: rtl/decoder_ref_onehot.sv
// decoder_ref_onehot: combinational one-hot reference for an N-to-2^N decoder.
// Optional macro DECODER_SWEEP_DISABLE_PASS_EN adds an enable input (low = all zeros). Revision: 1.0
`default_nettype none

module decoder_ref_onehot #(
    parameter int CODE_W = 5
) (
    input  logic [CODE_W-1:0]      code_i,
`ifdef DECODER_SWEEP_DISABLE_PASS_EN
    input  logic                   en_i,
`endif
    output logic [2**CODE_W-1:0]   expected_o
);

    localparam int SEL_W = 2**CODE_W;

    logic [SEL_W-1:0] w_one;
    logic [SEL_W-1:0] w_onehot;

    assign w_one    = {{(SEL_W-1){1'b0}}, 1'b1};
    assign w_onehot = w_one << code_i;

`ifdef DECODER_SWEEP_DISABLE_PASS_EN
    assign expected_o = en_i ? w_onehot : '0;
`else
    assign expected_o = w_onehot;
`endif

endmodule

`default_nettype wire

// File: rtl/decoder_sweep_checker.sv
// decoder_sweep_checker: sweeps every code into a decoder DUT and checks its one-hot output.
// Optional macro DECODER_SWEEP_DISABLE_PASS_EN adds dec_en and a second, disabled pass. Revision: 1.0
`default_nettype none

module decoder_sweep_checker
    import decoder_test_pkg::*;
#(
    parameter int CODE_W = 5,
    parameter int LAT    = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  dir,
    input  logic [2**CODE_W-1:0]  selection,
    output logic [CODE_W-1:0]     code,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [CODE_W:0]       err_count,
    output logic [CODE_W-1:0]     first_err_code,
`ifdef DECODER_SWEEP_DISABLE_PASS_EN
    output logic                  first_err_valid,
    output logic                  dec_en
`else
    output logic                  first_err_valid
`endif
);

    localparam int SEL_W  = 2**CODE_W;
    localparam int WAIT_W = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam logic [WAIT_W-1:0] C_LAT = WAIT_W'(LAT);

    logic [1:0]        state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              dir_q, dir_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CODE_W:0]   err_q, err_d;
    logic [CODE_W-1:0] ferr_code_q, ferr_code_d;
    logic              ferr_valid_q, ferr_valid_d;
    logic              pass_q, pass_d;
`ifdef DECODER_SWEEP_DISABLE_PASS_EN
    logic              pass2_q, pass2_d;
    logic              dec_en_q, dec_en_d;
`endif

    logic [SEL_W-1:0]  w_expected;
    logic [CODE_W-1:0] w_first_code;
    logic [CODE_W-1:0] w_last_code;
    logic              w_mismatch;

    decoder_ref_onehot #(
        .CODE_W (CODE_W)
    ) u_ref (
        .code_i     (code_q),
`ifdef DECODER_SWEEP_DISABLE_PASS_EN
        .en_i       (dec_en_q),
`endif
        .expected_o (w_expected)
    );

    assign w_first_code = (dir_q == DIR_DOWN) ? '1 : '0;
    assign w_last_code  = (dir_q == DIR_DOWN) ? '0 : '1;
    // Case inequality so X/Z on the DUT output is flagged in simulation
    assign w_mismatch   = (selection !== w_expected);

    always_comb begin
        state_d      = state_q;
        code_d       = code_q;
        dir_d        = dir_q;
        wait_d       = wait_q;
        err_d        = err_q;
        ferr_code_d  = ferr_code_q;
        ferr_valid_d = ferr_valid_q;
        pass_d       = pass_q;
`ifdef DECODER_SWEEP_DISABLE_PASS_EN
        pass2_d      = pass2_q;
        dec_en_d     = dec_en_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    code_d       = (dir == DIR_DOWN) ? '1 : '0;
                    dir_d        = dir;
                    wait_d       = C_LAT;
                    err_d        = '0;
                    ferr_code_d  = '0;
                    ferr_valid_d = 1'b0;
                    pass_d       = 1'b0;
                    state_d      = ST_RUN;
`ifdef DECODER_SWEEP_DISABLE_PASS_EN
                    pass2_d      = PASS_ONE;
                    dec_en_d     = 1'b1;
`endif
                end
            end
            ST_RUN: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - 1'b1;
                end else begin
                    if (w_mismatch) begin
                        // Saturate: two passes can exceed the counter range
                        err_d = (err_q == '1) ? err_q : err_q + 1'b1;
                        if (!ferr_valid_q) begin
                            ferr_code_d  = code_q;
                            ferr_valid_d = 1'b1;
                        end
                    end
                    if (code_q == w_last_code) begin
`ifdef DECODER_SWEEP_DISABLE_PASS_EN
                        if (pass2_q == PASS_ONE) begin
                            pass2_d  = PASS_TWO;
                            dec_en_d = 1'b0;
                            code_d   = w_first_code;
                            wait_d   = C_LAT;
                        end else begin
                            state_d = ST_DONE;
                            pass_d  = (err_d == '0);
                        end
`else
                        state_d = ST_DONE;
                        pass_d  = (err_d == '0);
`endif
                    end else begin
                        code_d = (dir_q == DIR_DOWN) ? code_q - 1'b1 : code_q + 1'b1;
                        wait_d = C_LAT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            code_q       <= '0;
            dir_q        <= DIR_UP;
            wait_q       <= '0;
            err_q        <= '0;
            ferr_code_q  <= '0;
            ferr_valid_q <= 1'b0;
            pass_q       <= 1'b0;
`ifdef DECODER_SWEEP_DISABLE_PASS_EN
            pass2_q      <= PASS_ONE;
            dec_en_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            code_q       <= code_d;
            dir_q        <= dir_d;
            wait_q       <= wait_d;
            err_q        <= err_d;
            ferr_code_q  <= ferr_code_d;
            ferr_valid_q <= ferr_valid_d;
            pass_q       <= pass_d;
`ifdef DECODER_SWEEP_DISABLE_PASS_EN
            pass2_q      <= pass2_d;
            dec_en_q     <= dec_en_d;
`endif
        end
    end

    assign code            = code_q;
    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_code  = ferr_code_q;
    assign first_err_valid = ferr_valid_q;
`ifdef DECODER_SWEEP_DISABLE_PASS_EN
    assign dec_en          = dec_en_q;
`endif

endmodule

`default_nettype wire
